// File: rtl/board_builder.sv
// Builds a 64-square occupancy board from white/black piece location vectors,
// one piece per cycle, with first-writer-wins collision detection.
module board_builder (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [95:0]  locationVectorWhite,
  input  logic [95:0]  locationVectorBlack,
  input  logic [15:0]  aliveVectorWhite,
  input  logic [15:0]  aliveVectorBlack,
  output logic [383:0] board,
  output logic         busy,
  output logic         done,
  output logic         collision
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} stateType;

  stateType state, stateNext;

  logic [95:0] snapWhite, snapBlack;
  logic [15:0] snapAliveWhite, snapAliveBlack;
  logic [4:0]  counter;

  logic [3:0]  pieceIndex;
  logic        isBlack;
  logic [6:0]  pieceBase;
  logic [5:0]  location;
  logic        pieceAlive;
  logic [5:0]  square;
  logic [8:0]  squareBase;
  logic        squareOccupied;

  // Decode the piece selected by the counter: 0..15 white, 16..31 black.
  // A location holds row in its low three bits and column above it.
  always_comb begin
    pieceIndex     = counter[3:0];
    isBlack        = counter[4];
    pieceBase      = 7'(pieceIndex) * 7'd6;
    location       = isBlack ? snapBlack[pieceBase +: 6] : snapWhite[pieceBase +: 6];
    pieceAlive     = isBlack ? snapAliveBlack[pieceIndex] : snapAliveWhite[pieceIndex];
    square         = {location[2:0], location[5:3]};
    squareBase     = 9'(square) * 9'd6;
    squareOccupied = board[squareBase + 9'd5];
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = SCAN;
      SCAN:    if (counter == 5'd31) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Piece ID is 15-k, which is simply the bitwise inverse of the 4-bit index.
  always_ff @(posedge clock) begin
    if (!reset) begin
      board          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      collision      <= 1'b0;
      counter        <= '0;
      snapWhite      <= '0;
      snapBlack      <= '0;
      snapAliveWhite <= '0;
      snapAliveBlack <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snapWhite      <= locationVectorWhite;
            snapBlack      <= locationVectorBlack;
            snapAliveWhite <= aliveVectorWhite;
            snapAliveBlack <= aliveVectorBlack;
            board          <= '0;
            collision      <= 1'b0;
            counter        <= '0;
            busy           <= 1'b1;
          end
        end
        SCAN: begin
          if (pieceAlive) begin
            if (squareOccupied) collision <= 1'b1;
            else board[squareBase +: 6] <= {1'b1, ~isBlack, ~pieceIndex};
          end
          counter <= counter + 5'd1;
          if (counter == 5'd31) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        DONE: done <= 1'b0;
        default: done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_board_builder.sv
// Randomized bench for board_builder, checked against a piece-by-piece
// placement model of the board rules.
module tb_board_builder;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [95:0]  locWhite, locBlack;
  logic [15:0]  aliveWhite, aliveBlack;
  logic [383:0] board;
  logic         busy, done, collision;

  int checks = 0;
  int errors = 0;

  logic [383:0] expBoard;
  logic         expColl;

  always #5 clock = ~clock;

  board_builder dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .locationVectorWhite(locWhite),
    .locationVectorBlack(locBlack),
    .aliveVectorWhite(aliveWhite),
    .aliveVectorBlack(aliveBlack),
    .board(board),
    .busy(busy),
    .done(done),
    .collision(collision)
  );

  // Place white pieces 0..15 then black 0..15; an occupied square keeps its first owner.
  task automatic computeExpected(input logic [95:0] w, input logic [95:0] b,
                                 input logic [15:0] aw, input logic [15:0] ab);
    expBoard = '0;
    expColl  = 1'b0;
    for (int p = 0; p < 32; p++) begin
      int k;
      int s;
      logic white;
      logic alive;
      logic [5:0] loc;
      k     = p % 16;
      white = (p < 16);
      loc   = white ? w[6*k +: 6] : b[6*k +: 6];
      alive = white ? aw[k] : ab[k];
      s     = int'(loc[2:0]) * 8 + int'(loc[5:3]);
      if (alive) begin
        if (expBoard[6*s+5]) expColl = 1'b1;
        else expBoard[6*s +: 6] = {1'b1, white, 4'(15 - k)};
      end
    end
  endtask

  task automatic randomizeInputs();
    locWhite   = {$urandom, $urandom, $urandom};
    locBlack   = {$urandom, $urandom, $urandom};
    aliveWhite = 16'($urandom);
    aliveBlack = 16'($urandom);
  endtask

  // Pulses start, optionally pokes start mid-scan or perturbs the inputs after
  // acceptance, and reports the cycles from the accepting edge to done (-1 = none).
  task automatic runBuild(input bit midPulse, input bit perturb, output int latency);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    if (perturb) begin
      locWhite   = {$urandom, $urandom, $urandom};
      aliveWhite = 16'hFFFF;
    end
    latency = -1;
    for (int c = 1; c <= 60; c++) begin
      if (midPulse) start = (c == 5);
      @(posedge clock);
      @(negedge clock);
      if (done) begin
        latency = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    randomizeInputs();
    repeat (4) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++;
    if (collision !== 1'b0) begin errors++; $display("[TB] FAIL reset_collision: got %b expected 0", collision); end
    checks++;
    if (board !== '0) begin errors++; $display("[TB] FAIL reset_board: got %h expected 0", board); end
    reset = 1'b1;
    start = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_initial_position();
    int backCol[8] = '{0, 7, 1, 6, 2, 5, 3, 4};
    int latency;
    for (int k = 0; k < 16; k++) begin
      int row;
      int col;
      row = (k < 8) ? 1 : 0;
      col = (k < 8) ? k : backCol[k-8];
      locWhite[6*k +: 6] = {3'(col), 3'(row)};
      locBlack[6*k +: 6] = {3'(col), 3'(7 - row)};
    end
    aliveWhite = 16'hFFFF;
    aliveBlack = 16'hFFFF;
    computeExpected(locWhite, locBlack, aliveWhite, aliveBlack);
    runBuild(1'b0, 1'b0, latency);
    checks++;
    if (latency != 32) begin errors++; $display("[TB] FAIL init_latency: got %0d expected 32", latency); end
    checks++;
    if (board[8*6 +: 6] !== 6'b111111) begin errors++; $display("[TB] FAIL init_sq8: got %b expected 111111", board[8*6 +: 6]); end
    checks++;
    if (board[0 +: 6] !== 6'b110111) begin errors++; $display("[TB] FAIL init_sq0: got %b expected 110111", board[0 +: 6]); end
    checks++;
    if (board[48*6 +: 6] !== 6'b101111) begin errors++; $display("[TB] FAIL init_sq48: got %b expected 101111", board[48*6 +: 6]); end
    checks++;
    if (board[16*6 +: 192] !== '0) begin errors++; $display("[TB] FAIL init_middle: got %h expected 0", board[16*6 +: 192]); end
    checks++;
    if (collision !== 1'b0) begin errors++; $display("[TB] FAIL init_collision: got %b expected 0", collision); end
    checks++;
    if (board !== expBoard) begin errors++; $display("[TB] FAIL init_board: got %h expected %h", board, expBoard); end
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL init_done_width: got %b expected 0", done); end
  endtask

  task automatic test_all_dead();
    int latency;
    randomizeInputs();
    aliveWhite = '0;
    aliveBlack = '0;
    runBuild(1'b0, 1'b0, latency);
    checks++;
    if (latency != 32) begin errors++; $display("[TB] FAIL dead_latency: got %0d expected 32", latency); end
    checks++;
    if (board !== '0) begin errors++; $display("[TB] FAIL dead_board: got %h expected 0", board); end
    checks++;
    if (collision !== 1'b0) begin errors++; $display("[TB] FAIL dead_collision: got %b expected 0", collision); end
  endtask

  task automatic test_collision();
    int latency;
    randomizeInputs();
    aliveWhite = 16'h0001;
    aliveBlack = 16'h8000;
    locWhite[0 +: 6]  = {3'd4, 3'd3};
    locBlack[90 +: 6] = {3'd4, 3'd3};
    computeExpected(locWhite, locBlack, aliveWhite, aliveBlack);
    runBuild(1'b0, 1'b0, latency);
    checks++;
    if (board[28*6 +: 6] !== 6'b111111) begin errors++; $display("[TB] FAIL coll_sq28: got %b expected 111111", board[28*6 +: 6]); end
    checks++;
    if (collision !== 1'b1) begin errors++; $display("[TB] FAIL coll_flag: got %b expected 1", collision); end
    checks++;
    if (board !== expBoard) begin errors++; $display("[TB] FAIL coll_board: got %h expected %h", board, expBoard); end
    repeat (3) @(negedge clock);
    checks++;
    if (collision !== 1'b1) begin errors++; $display("[TB] FAIL coll_hold: got %b expected 1", collision); end
    aliveBlack = '0;
    computeExpected(locWhite, locBlack, aliveWhite, aliveBlack);
    runBuild(1'b0, 1'b0, latency);
    checks++;
    if (collision !== 1'b0) begin errors++; $display("[TB] FAIL coll_clear: got %b expected 0", collision); end
    checks++;
    if (board !== expBoard) begin errors++; $display("[TB] FAIL coll_clear_board: got %h expected %h", board, expBoard); end
  endtask

  task automatic test_random();
    int latency;
    for (int i = 0; i < 8; i++) begin
      randomizeInputs();
      computeExpected(locWhite, locBlack, aliveWhite, aliveBlack);
      runBuild(i[0], 1'b0, latency);
      checks++;
      if (latency != 32) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected 32", i, latency); end
      checks++;
      if (board !== expBoard) begin errors++; $display("[TB] FAIL rand%0d_board: got %h expected %h", i, board, expBoard); end
      checks++;
      if (collision !== expColl) begin errors++; $display("[TB] FAIL rand%0d_collision: got %b expected %b", i, collision, expColl); end
      repeat (2) @(negedge clock);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("[TB] FAIL rand%0d_idle: got busy=%b done=%b expected 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int doneSeen;
    int latency;
    randomizeInputs();
    aliveWhite = 16'hFFFF;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (10) begin @(posedge clock); @(negedge clock); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_before: got %b expected 1", busy); end
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    checks++;
    if (board !== '0) begin errors++; $display("[TB] FAIL abort_board: got %h expected 0", board); end
    doneSeen = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) doneSeen++;
    end
    checks++;
    if (doneSeen != 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", doneSeen); end
    randomizeInputs();
    computeExpected(locWhite, locBlack, aliveWhite, aliveBlack);
    runBuild(1'b0, 1'b0, latency);
    checks++;
    if (latency != 32) begin errors++; $display("[TB] FAIL abort_fresh_latency: got %0d expected 32", latency); end
    checks++;
    if (board !== expBoard) begin errors++; $display("[TB] FAIL abort_fresh_board: got %h expected %h", board, expBoard); end
  endtask

  task automatic test_back_to_back();
    int doneCycle[$];
    randomizeInputs();
    computeExpected(locWhite, locBlack, aliveWhite, aliveBlack);
    @(negedge clock);
    start = 1'b1;
    for (int c = 1; c <= 150 && doneCycle.size() < 3; c++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) begin
        doneCycle.push_back(c);
        checks++;
        if (board !== expBoard) begin errors++; $display("[TB] FAIL b2b_board: got %h expected %h", board, expBoard); end
      end
    end
    start = 1'b0;
    checks++;
    if (doneCycle.size() != 3) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d pulses expected 3", doneCycle.size());
    end else begin
      checks++;
      if (doneCycle[0] != 33) begin errors++; $display("[TB] FAIL b2b_first: got %0d expected 33", doneCycle[0]); end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (doneCycle[i] - doneCycle[i-1] != 34) begin
          errors++; $display("[TB] FAIL b2b_period: got %0d expected 34", doneCycle[i] - doneCycle[i-1]);
        end
      end
    end
    repeat (40) @(negedge clock);
  endtask

  task automatic test_snapshot();
    int latency;
    randomizeInputs();
    computeExpected(locWhite, locBlack, aliveWhite, aliveBlack);
    runBuild(1'b0, 1'b1, latency);
    checks++;
    if (latency != 32) begin errors++; $display("[TB] FAIL snap_latency: got %0d expected 32", latency); end
    checks++;
    if (board !== expBoard) begin errors++; $display("[TB] FAIL snap_board: got %h expected %h", board, expBoard); end
    checks++;
    if (collision !== expColl) begin errors++; $display("[TB] FAIL snap_collision: got %b expected %b", collision, expColl); end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    locWhite = '0;
    locBlack = '0;
    aliveWhite = '0;
    aliveBlack = '0;
    test_reset();
    test_initial_position();
    test_all_dead();
    test_collision();
    test_random();
    test_reset_mid_scan();
    test_back_to_back();
    test_snapshot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_builder.md
BOARD_BUILDER -- requirements
Module: board_builder

Interface
REQ-001 clock  input  1  single system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-003 start  input  1  request a board rebuild; honoured only in IDLE.
REQ-004 locationVectorWhite  input  96  16 white pieces x 6 bits; piece k at [6k +: 6]; row = [6k +: 3], col = [6k+3 +: 3].
REQ-005 locationVectorBlack  input  96  same layout for black.
REQ-006 aliveVectorWhite  input  16  bit k = 1: white piece k on board.
REQ-007 aliveVectorBlack  input  16  same for black.
REQ-008 board  output  384  64 squares x 6 bits; square s = row*8+col at [6s +: 6]; bit5 occupied, bit4 colour (1 white, 0 black), bits3:0 piece ID.
REQ-009 busy  output  1  high while a build is in progress.
REQ-010 done  output  1  one-cycle pulse; board complete and valid.
REQ-011 collision  output  1  sticky: two alive pieces mapped to one square during the current build.

Function
REQ-012 Piece ID SHALL be 15-k for piece index k: pawns k=0..7 give IDs 1111..1000, R1=0111, R2=0110, N1=0101, N2=0100, B1=0011, B2=0010, Q1=0001, K1=0000.
REQ-013 FSM states SHALL be IDLE, SCAN and DONE.
REQ-014 IDLE with start=1 at edge N: snapshot all four input vectors; zero board; clear collision; clear piece counter to 0; busy<=1; go to SCAN.
REQ-015 SCAN: one piece per cycle from the snapshot; counter 0..15 selects white k=counter, counter 16..31 selects black k=counter-16.
REQ-016 Alive piece, target square unoccupied: write {1, colour, 15-k} to the square.
REQ-017 Alive piece, target already occupied: leave the square unchanged (first writer wins) and set collision<=1.
REQ-018 Dead piece: no write; the cycle is still consumed (fixed latency).
REQ-019 Counter SHALL be 5 bits; at edge N+32 (piece 31 processed) go to DONE with done<=1 and busy<=0.
REQ-020 DONE: done stays high for exactly one cycle; next edge gives done<=0, state IDLE.
REQ-021 Latency SHALL be fixed: done is high in the cycle after edge N+32, independent of alive count.
REQ-022 board and collision SHALL hold their values from DONE until the next accepted start.
REQ-023 start while in SCAN or DONE SHALL be ignored; it is not queued.
REQ-024 Input changes after edge N SHALL NOT affect the build in progress (snapshot only).
REQ-025 start asserted in the same cycle that done is high SHALL be ignored; it is accepted the next cycle in IDLE if still high.

Reset
REQ-026 reset=0 at any edge SHALL force IDLE, board=0, busy=0, done=0, collision=0, counter=0, snapshots=0.
REQ-027 Reset in mid-SCAN SHALL abort the build; no done pulse is produced for the aborted build.
REQ-028 reset=0 SHALL take priority over start.

Verification
REQ-029 Initial position (white pawns row 1 cols 0..7, back rank row 0; black rows 6/7; all alive), start pulse -> done exactly in the cycle after edge N+32; square 8 = 6'b111111; square 0 = 6'b110111; square 48 = 6'b101111; squares 16..47 = 0; collision=0.
REQ-030 All alive bits 0 -> board all zero, done after the same 33-cycle latency.
REQ-031 White P1 and black K1 both at row 3 col 4, both alive -> square 28 = 6'b111111 and collision=1; collision cleared on the next start.
REQ-032 Reset pulled low at SCAN cycle 10 -> next cycle busy=0, board=0; no done pulse; a fresh start then completes normally.
REQ-033 start held high continuously -> builds back to back, one done per 34 cycles; start pulses during SCAN have no effect.
REQ-034 Change locationVectorWhite one cycle after start -> resulting board reflects the pre-start values.
